// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// - clr_state_t     : clear sequencer states (IDLE, CLEAR)
// - DEFAULT_WIDTH   : default data word width, reused by the processor top
// - DEFAULT_DEPTH   : default register count, reused by the processor top
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register index once and zeroes it.
// The accepting edge (IDLE with ClearReq) already clears index 0, so a
// full clear takes DEPTH edges and Busy is high for DEPTH-1 cycles.
// Ports:
//   Clk       - clock, posedge
//   Reset     - synchronous active-high reset
//   ClearReq  - start request, honoured only in IDLE
//   Busy      - registered, high while in CLEAR
//   clr_en    - zero register clr_idx at the coming edge
//   clr_idx   - index being cleared this cycle
//   state_dbg - current FSM state, for observation
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ClearReq,
  output logic          Busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx,
  output clr_state_t    state_dbg
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    clr_idx   = '0;
    case (state)
      IDLE: begin
        if (ClearReq) begin
          clr_en    = 1'b1;
          clr_idx   = '0;
          cnt_nxt   = AW'(1);
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        // ClearReq is ignored here; no restart mid-sequence.
        clr_en  = 1'b1;
        clr_idx = cnt;
        if (cnt == LAST_IDX) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign Busy      = (state == CLEAR);
  assign state_dbg = state;

endmodule : regfile_clear_seq

// File: rtl/regfile_multi.sv
// Parametrised register file: one write port, two combinational read
// ports, optional same-cycle write-to-read bypass, and a multi-cycle clear.
// Ports:
//   Clk, Reset          - clock and synchronous active-high reset
//   WriteEn/Waddr/DataIn - write port
//   RaddrA, RaddrB      - read addresses
//   ClearReq            - start a clear of all registers
//   DataOutA, DataOutB  - read data (combinational)
//   Busy                - high while the clear sequencer runs
// Write acceptance: a write is taken at the posedge only when WriteEn=1,
// Busy=0 and Waddr<DEPTH; otherwise it is silently dropped (no stall, no
// error). Out-of-range read addresses return 0.
module regfile_multi
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WriteEn,
  input  logic [AW-1:0]    Waddr,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [AW-1:0]    RaddrA,
  input  logic [AW-1:0]    RaddrB,
  input  logic             ClearReq,
  output logic [WIDTH-1:0] DataOutA,
  output logic [WIDTH-1:0] DataOutB,
  output logic             Busy
);

  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic          clr_en;
  logic [AW-1:0] clr_idx;
  clr_state_t    clr_state;
  logic          wr_ok, a_ok, b_ok;

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .Clk       (Clk),
    .Reset     (Reset),
    .ClearReq  (ClearReq),
    .Busy      (Busy),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .state_dbg (clr_state)
  );

  assign wr_ok = WriteEn && !Busy && ({1'b0, Waddr} < DEPTH_W);
  assign a_ok  = ({1'b0, RaddrA} < DEPTH_W);
  assign b_ok  = ({1'b0, RaddrB} < DEPTH_W);

  // The clear assignment comes after the write so that, on the accepting
  // edge, a write to index 0 loses to the clear; writes elsewhere survive.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        regs[Waddr] <= DataIn;
      end
      if (clr_en) begin
        regs[clr_idx] <= '0;
      end
    end
  end

  always_comb begin
    DataOutA = '0;
    if (a_ok) begin
      DataOutA = regs[RaddrA];
    end
    if ((BYPASS != 0) && wr_ok && (Waddr == RaddrA)) begin
      DataOutA = DataIn;
    end
  end

  always_comb begin
    DataOutB = '0;
    if (b_ok) begin
      DataOutB = regs[RaddrB];
    end
    if ((BYPASS != 0) && wr_ok && (Waddr == RaddrB)) begin
      DataOutB = DataIn;
    end
  end

endmodule : regfile_multi

// File: tb/tb_regfile_multi.sv
// Bench for regfile_multi with DEPTH=5 (so out-of-range addresses exist),
// WIDTH=16, BYPASS=1. The driver pushes the expected outputs of each cycle
// into exp_q; the monitor pops and compares on the falling edge.
module tb_regfile_multi;

  localparam int W  = 16;
  localparam int D  = 5;
  localparam int BP = 1;
  localparam int AW = $clog2(D);

  logic          Clk;
  logic          Reset;
  logic          WriteEn;
  logic [AW-1:0] Waddr;
  logic [W-1:0]  DataIn;
  logic [AW-1:0] RaddrA;
  logic [AW-1:0] RaddrB;
  logic          ClearReq;
  logic [W-1:0]  DataOutA;
  logic [W-1:0]  DataOutB;
  logic          Busy;

  regfile_multi #(.WIDTH(W), .DEPTH(D), .BYPASS(BP)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .WriteEn  (WriteEn),
    .Waddr    (Waddr),
    .DataIn   (DataIn),
    .RaddrA   (RaddrA),
    .RaddrB   (RaddrB),
    .ClearReq (ClearReq),
    .DataOutA (DataOutA),
    .DataOutB (DataOutB),
    .Busy     (Busy)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // m_regs: register contents. clr_pos: -1 when no clear is running,
  // otherwise the index that the next edge zeroes.
  logic [W-1:0] m_regs [D];
  int           clr_pos;

  logic [2*W:0] exp_q [$];   // {busy, out_a, out_b}
  int n_compared   = 0;
  int n_mismatched = 0;

  function automatic logic [W-1:0] model_read(int ra, logic we, int wa, logic [W-1:0] din,
                                              logic busy);
    if (BP != 0 && we && !busy && wa < D && wa == ra) return din;
    if (ra < D) return m_regs[ra];
    return '0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic we, input int wa, input int din,
                       input int ra, input int rb, input logic clr);
    logic         busy;
    logic [W-1:0] d, ea, eb;
    d        = W'(din);
    Reset    = rst;
    WriteEn  = we;
    Waddr    = AW'(wa);
    DataIn   = d;
    RaddrA   = AW'(ra);
    RaddrB   = AW'(rb);
    ClearReq = clr;
    busy = (clr_pos >= 0);
    ea   = model_read(ra, we, wa, d, busy);
    eb   = model_read(rb, we, wa, d, busy);
    exp_q.push_back({busy, ea, eb});
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < D; i++) m_regs[i] = '0;
      clr_pos = -1;
    end else begin
      if (we && !busy && wa < D) m_regs[wa] = d;
      if (busy) begin
        m_regs[clr_pos] = '0;
        clr_pos = clr_pos + 1;
        if (clr_pos == D) clr_pos = -1;
      end else if (clr) begin
        m_regs[0] = '0;
        clr_pos = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int ra, input int rb);
    drive(1'b0, 1'b0, 0, 0, ra, rb, 1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    logic [2*W:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy",  W'(Busy), W'(e[2*W]));
      check("out_a", DataOutA, e[2*W-1:W]);
      check("out_b", DataOutB, e[W-1:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; WriteEn = 1'b0; Waddr = '0; DataIn = '0;
    RaddrA = '0; RaddrB = '0; ClearReq = 1'b0;
    @(posedge Clk);
    for (int i = 0; i < D; i++) m_regs[i] = '0;
    clr_pos = -1;
    #1;

    // Reset after a write clears everything.
    drive(1'b0, 1'b1, 2, 'hAA, 2, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 2, 3, 1'b0);
    idle(0, 1); idle(2, 3); idle(4, 2);

    // Same-cycle bypass on A, B unaffected.
    drive(1'b0, 1'b1, 3, 'h5C, 3, 1, 1'b0);
    idle(3, 1);

    // Load all, then clear and watch the sweep.
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, i, 'h11 * (i + 1), i, (i + 1) % D, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1, 1'b1);
    for (int k = 0; k < D + 1; k++) idle(k % D, (k + 1) % D);

    // Write during clear is dropped, no bypass; write to 0 on accept edge loses.
    drive(1'b0, 1'b1, 3, 'h1234, 3, 0, 1'b0);
    drive(1'b0, 1'b1, 0, 'h7777, 0, 3, 1'b1);
    drive(1'b0, 1'b1, 3, 'hFF, 3, 0, 1'b0);
    drive(1'b0, 1'b1, 4, 'hABCD, 4, 3, 1'b0);
    for (int k = 0; k < D; k++) idle(3, 4);

    // Out-of-range write and reads.
    drive(1'b0, 1'b1, 2, 'h0102, 2, 2, 1'b0);
    drive(1'b0, 1'b1, 6, 'hBEEF, 6, 2, 1'b0);
    idle(6, 7); idle(5, 2);

    // Reset on the second clear edge, then a fresh clear from reg 0.
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, i, 'hA0 + i, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 1, 2, 1'b1);
    idle(3, 4);
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, i, 'hC0 + i, i, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1, 1'b1);
    for (int k = 0; k < D + 1; k++) idle(k % D, 4);

    // ClearReq held high restarts immediately after each sweep.
    for (int k = 0; k < 2 * D + 2; k++) drive(1'b0, 1'b1, k % D, 'h300 + k, k % D, 1, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(7),
            $urandom_range(16'hFFFF), $urandom_range(7), $urandom_range(7),
            ($urandom_range(15) == 0));
    end
    idle(0, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_regfile_multi
